// File: rtl/shift_sequencer_if.sv
// shift_sequencer_if: request/result handshake bundle for shift_sequencer.
//
// Signals:
//   in_valid / in_ready      request handshake (requester -> sequencer)
//   in_data [WIDTH]          operand to shift
//   in_shift [2]             00 pass, 01 logical left, 10 logical right, 11 arithmetic right
//   in_amt [AMT_W]           number of bit positions to shift
//   out_valid / out_ready    result handshake (sequencer -> consumer)
//   out_data [WIDTH]         shifted result, meaningful while out_valid=1
//   busy                     sequencer is not idle
//
// Modports:
//   slave  - the sequencer side
//   master - the requester/consumer side
interface shift_sequencer_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned AMT_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_shift;
    logic [AMT_W-1:0] in_amt;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             busy;

    modport slave (
        input  in_valid, in_data, in_shift, in_amt, out_ready,
        output in_ready, out_valid, out_data, busy
    );

    modport master (
        output in_valid, in_data, in_shift, in_amt, out_ready,
        input  in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle shift controller for the datapath shifter.
//
// Accepts one request (operand, shift code, amount) at a time, performs the shift as a series
// of per-clock steps, then holds the result until the consumer takes it.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    shift_sequencer_if.slave (request/result handshakes, busy)
//
// Build option:
//   SHIFT_SEQ_FAST_EN - when defined, a step shifts by 4 bits while at least 4 remain,
//                       otherwise by 1. Results are identical; only latency changes.
module shift_sequencer #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned AMT_W = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    shift_sequencer_if.slave     bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [1:0] OP_PASS = 2'b00;
    localparam logic [1:0] OP_SLL  = 2'b01;
    localparam logic [1:0] OP_SRL  = 2'b10;
    localparam logic [1:0] OP_SRA  = 2'b11;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;

    logic [2:0]       step;
    logic [WIDTH-1:0] acc_step;

    // Size of the current step in bit positions.
    always_comb begin
`ifdef SHIFT_SEQ_FAST_EN
        step = (cnt_q >= AMT_W'(4)) ? 3'd4 : 3'd1;
`else
        step = 3'd1;
`endif
    end

    // One step of the latched shift kind.
    always_comb begin
        acc_step = acc_q;
        case (op_q)
            OP_SLL:  acc_step = acc_q << step;
            OP_SRL:  acc_step = acc_q >> step;
            OP_SRA:  acc_step = WIDTH'($signed(acc_q) >>> step);
            default: acc_step = acc_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    acc_d = bus.in_data;
                    op_d  = bus.in_shift;
                    cnt_d = bus.in_amt;
                    if (bus.in_shift == OP_PASS || bus.in_amt == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                acc_d = acc_step;
                cnt_d = cnt_q - AMT_W'(step);
                if (cnt_d == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            op_q    <= OP_PASS;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_data  = acc_q;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multi-cycle shift controller for the 16-bit datapath shifter.
- Accepts a shift operand, a 2-bit shift code and a shift amount over a valid/ready handshake.
- Iterates single-bit shift steps (one per clock) until the amount is exhausted, then presents the result over a second valid/ready handshake.
- Sits between the decode/execute control and the datapath; shifts by more than one bit are built from it.

Parameters:
WIDTH, 16, data width of operand and result
AMT_W, 4, width of the shift-amount field (max amount 2^AMT_W-1)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  request valid
in_ready  output  1  sequencer can accept a request
in_data  input  WIDTH  operand to shift
in_shift  input  2  shift code: 00 pass, 01 logical left, 10 logical right, 11 arithmetic right
in_amt  input  AMT_W  number of bit positions to shift
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_data  output  WIDTH  shifted result
busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset, asynchronous on rst_n low, effective immediately regardless of state:
  - state=IDLE, acc=0, cnt=0, op=00.
  - in_ready=1 once reset deasserts; out_valid=0, out_data=0, busy=0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - Accept occurs on the edge where in_valid=1 (in_ready is 1 here).
  - On accept: acc<=in_data, op<=in_shift, cnt<=in_amt.
  - If in_shift==00 or in_amt==0, go to DONE (acc holds in_data unchanged).
  - Otherwise go to SHIFT.
- SHIFT, one step per edge:
  - 01: acc<={acc[WIDTH-2:0],0}
  - 10: acc<={0,acc[WIDTH-1:1]}
  - 11: acc<={acc[WIDTH-1],acc[WIDTH-1:1]}
  - cnt<=cnt-1 each step; when cnt==1 at the step edge, go to DONE.
  - in_ready=0; new requests are not accepted.
- DONE:
  - out_valid=1, out_data=acc; both held stable while out_ready=0.
  - On an edge with out_ready=1, go to IDLE; out_valid drops after that edge.
- Latency: out_valid rises exactly N edges after the accept edge for N=in_amt>=1; with N=0 or code 00 it rises on the accept edge itself.
- Throughput: one request at a time, no overlap.
  - in_ready is low from the accept edge until the edge after the out_ready handshake.
  - A request presented in the same cycle as the DONE handshake is not accepted; it is taken in the following IDLE cycle.
- Input changes while busy are ignored; only values latched at accept are used.
- out_data equals acc in all states; it is only meaningful while out_valid=1.
- busy = (state != IDLE).

Optional Feature:
- Macro: SHIFT_SEQ_FAST_EN.
- Defined:
  - In SHIFT, when cnt>=4, one edge performs a 4-bit shift of the same kind and sets cnt<=cnt-4.
  - Otherwise a 1-bit step is performed.
  - DONE is entered when the step brings cnt to 0.
  - Latency = floor(N/4) + (N mod 4) edges.
- Undefined: 1 bit per edge only; latency = N edges.
- Result values are identical in both builds.

Test Plan:
- Reset: hold rst_n=0 mid-SHIFT (in_data=0x1234, code 01, amt 8) -> out_valid=0, busy=0, in_ready=1 and out_data=0 asynchronously; after release, next request completes normally.
- Logical left: in_data=0x0001, code 01, amt 15, out_ready=1 -> out_data=0x8000; out_valid 15 edges after accept (6 with SHIFT_SEQ_FAST_EN).
- Right shifts:
  - in_data=0x8000, code 10, amt 15 -> 0x0001.
  - Same operand, code 11, amt 15 -> 0xFFFF.
  - in_data=0x8F00, code 11, amt 4 -> 0xF8F0.
- Zero/pass:
  - in_data=0xA5A5, amt 0, code 11 -> out_valid on accept edge, out_data=0xA5A5.
  - Code 00, amt 7 -> 0xA5A5, same timing.
- Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid and out_data stable, in_ready=0; second request held on in_valid is accepted one cycle after out_ready handshake.
- Input isolation: change in_data/in_shift/in_amt every cycle during SHIFT -> result depends only on values latched at accept (0x00F0, code 10, amt 4 -> 0x000F).
